// File: rtl/mul_pkg.sv
// mul_pkg: shared width, counter width and state encoding for the Booth multiplier
package mul_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/subtract followed by an arithmetic right shift of P
module booth_step #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic [2*WIDTH+1:0] p,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] p_next
);
  logic [WIDTH:0] u;
  logic [WIDTH:0] sum;
  always_comb begin
    u      = p[2*WIDTH+1:WIDTH+1];
    sum    = p[1:0] == 2'b01 ? u + m : p[1:0] == 2'b10 ? u - m : u;
    p_next = {sum[WIDTH], sum, p[WIDTH:1]};
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth signed multiplier with stall and flush handshake
module booth_mul_seq #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mul_pkg::*;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 2;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d, p_step;
  logic [WIDTH:0]  m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            accept, step, last, wr;
  booth_step #(.WIDTH(WIDTH)) u_step (.p(p_q), .m(m_q), .p_next(p_step));
  assign start_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign accept      = start_valid & start_ready & ~flush;
  assign stall       = busy | accept;
  assign step        = state_q == RUN && !flush;
  assign last        = cnt_q == CW'(WIDTH - 1);
  assign wr          = step && last;
  assign hi          = hi_q;
  assign lo          = lo_q;
  always_comb begin
    state_d = state_q == IDLE ? (accept ? RUN : IDLE)
            : state_q == RUN  ? (flush ? IDLE : last ? DONE : RUN)
            : IDLE;
    m_d     = accept ? {multiplicand[WIDTH-1], multiplicand} : m_q;
    p_d     = accept ? {{(WIDTH+1){1'b0}}, multiplier, 1'b0} : step ? p_step : p_q;
    cnt_d   = accept ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    hi_d    = wr ? p_step[2*WIDTH:WIDTH+1] : hi_q;
    lo_d    = wr ? p_step[WIDTH:1] : lo_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: table-driven scoreboard bench for the Booth multiplier
module tb_booth_mul_seq;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [63:0] p; } vec_t;
  typedef struct { logic [63:0] p; int acc; } exp_t;
  logic        clk = 0;
  logic        reset = 1;
  logic        start_valid = 0;
  logic        start_ready;
  logic [31:0] multiplicand = 0;
  logic [31:0] multiplier = 0;
  logic        flush = 0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  exp_t        sb[$];
  vec_t        vecs[11];
  booth_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      chk("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.p[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, e.p[31:0]});
        chk("latency", 64'(cyc - e.acc), 64'd32);
      end
    end
  end
  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !start_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    int n = 0;
    @(negedge clk);
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_op", {63'd0, start_ready}, 64'd1);
    start_valid = 1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk);
    #1;
    sb.push_back('{p, cyc});
    start_valid = 0;
    multiplicand = $urandom;
    multiplier = $urandom;
    wait_drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic signed [63:0] sa, sb64;
    logic [63:0] prior;
    bit seen;
    int dn0;
    #1;
    chk("rst_start_ready", {63'd0, start_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[5] = '{32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{32'd0, 32'h1234_5678, 64'h0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    for (int i = 9; i < 11; i++) begin
      vecs[i].a = $urandom;
      vecs[i].b = $urandom;
      sa = $signed(vecs[i].a);
      sb64 = $signed(vecs[i].b);
      vecs[i].p = sa * sb64;
    end
    for (int i = 0; i < 11; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);
    prior = vecs[10].p;
    @(negedge clk);
    start_valid = 1;
    flush = 1;
    multiplicand = 5;
    multiplier = 5;
    #1;
    chk("stall_flush_idle", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    chk("no_accept_on_flush", {63'd0, busy}, 64'd0);
    start_valid = 0;
    flush = 0;
    @(negedge clk);
    start_valid = 1;
    multiplicand = 2;
    multiplier = 2;
    @(posedge clk);
    #1;
    start_valid = 0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    chk("flush_idle_ready", {63'd0, start_ready}, 64'd1);
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    chk("flush_keeps_hilo", {hi, lo}, prior);
    repeat (40) @(negedge clk);
    chk("flush_no_done_hilo", {hi, lo}, prior);
    run_op(32'd4, 32'd4, 64'h10);
    @(negedge clk);
    start_valid = 1;
    multiplicand = 5;
    multiplier = 7;
    @(posedge clk);
    #1;
    start_valid = 0;
    repeat (19) @(posedge clk);
    #3;
    reset = 1;
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_ready", {63'd0, start_ready}, 64'd1);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    chk("arst_no_done", {32'd0, lo}, 64'd0);
    start_valid = 1;
    multiplicand = 32'd9;
    multiplier = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    sb.push_back('{64'hFFFF_FFFF_FFFF_FFE5, cyc});
    dn0 = done_cnt;
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        multiplicand = $urandom;
        multiplier = $urandom;
        if (n == 5) begin
          chk("held_stall", {63'd0, stall}, 64'd1);
          chk("held_ready", {63'd0, start_ready}, 64'd0);
        end
      end
    end
    start_valid = 0;
    chk("held_done_seen", {63'd0, seen}, 64'd1);
    wait_drain();
    repeat (40) @(negedge clk);
    chk("held_one_done", 64'(done_cnt - dn0), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Multi-cycle signed multiply unit for the CPU execute stage. It accepts a 32×32 signed multiply request through a valid/ready handshake and runs radix-2 Booth recoding for exactly 32 iterations. It then latches the 64-bit product into HI/LO and pulses `done`. While a multiply is in flight it drives a pipeline stall and honours a flush from the hazard logic.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  request present this cycle.
- `start_ready`  out  1  unit can accept a request; high only in IDLE.
- `multiplicand`  in  WIDTH  signed operand M; sampled on accept.
- `multiplier`  in  WIDTH  signed operand Q; sampled on accept.
- `flush`  in  1  abort any in-flight operation.
- `busy`  out  1  high in RUN and DONE.
- `stall`  out  1  equals `busy | (start_valid & start_ready & ~flush)`; holds the decode stage.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `hi`  out  WIDTH  product bits [63:32]; held until the next completion.
- `lo`  out  WIDTH  product bits [31:0]; held until the next completion.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **IDLE:**
  - Accept occurs when `start_valid & start_ready & ~flush`.
  - On accept, load M into a 33-bit sign-extended register and load the working register P (66 bits).
  - P is laid out as U[32:0]=0, then Q[31:0]=multiplier, then q₋₁=0.
  - Clear the step counter to 0 and go to RUN.
- **RUN:** each cycle performs one Booth step.
  - Examine the pair {Q[0], q₋₁}.
  - 01: U ← U + M.
  - 10: U ← U − M.
  - 00 or 11: U unchanged.
  - Then shift all of P arithmetically right by 1; U[32] is replicated.
  - Increment the counter. After the step taken with counter = WIDTH−1, go to DONE.
- **DONE:**
  - Write `hi` ← U[31:0] and `lo` ← Q (the post-shift values).
  - Assert `done` for this cycle only, then return to IDLE.
- Width rules:
  - U is 33 bits so that U − M cannot overflow when M = −2^31.
  - The final product is the two's-complement 64-bit result {U[31:0], Q}.
- `flush` in RUN:
  - Return to IDLE next cycle.
  - No `done`; HI/LO are unchanged.
  - The counter and P are don't-care.
- `flush` in DONE: ignored. The HI/LO write and `done` still happen, because the result is committed.
- `flush` with `start_valid` in IDLE: flush wins and the request is not accepted.
- `start_valid` while busy: ignored (`start_ready` is low). Operands are not re-sampled.
- `reset` (any state, asynchronous):
  - State goes to IDLE; counter, P, `hi`, `lo` and `done` all go to 0.
  - `start_ready` becomes 1 and `busy` becomes 0.

## Timing
- Accept at edge 0, RUN during cycles 1–32, DONE in cycle 33 (`done` high, `hi`/`lo` valid at the end of that edge).
- The earliest next accept is cycle 34, i.e. a 34-cycle initiation interval.
- Reset values: `start_ready`=1, `busy`=0, `stall`=0 (with `start_valid` low), `done`=0, `hi`=0, `lo`=0.
- `start_ready`, `busy` and `done` are registered-state decodes and are glitch-free with respect to the state register.
- `stall` is combinational in `start_valid` and `flush`.
- Operands may change after the accept edge without affecting the result.

## Structure
- Shared package `mul_pkg` holds:
  - the state encoding localparams (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - `WIDTH`;
  - the counter width `$clog2(WIDTH)+1`.
- Sub-module `booth_step`: purely combinational. It takes (P, M) and returns the next P, performing the add/subtract followed by the arithmetic shift. It is instantiated once inside the sequencer.
- The sequencer owns the FSM, counter, P, M and the HI/LO registers.

## Test plan
- 3 × 5 → `done` at cycle 33, `hi`=0x00000000, `lo`=0x0000000F.
- −7 × 6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6. Then 0x7FFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFF, `lo`=0x80000001.
- 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000 (checks the 33-bit U path).
- Accept 2 × 2 and raise `flush` in RUN cycle 10:
  - expect IDLE at cycle 11, no `done`, and HI/LO keeping the prior result;
  - then accept 4 × 4 → `lo`=0x10.
- Assert `reset` at RUN cycle 20 → all outputs 0 immediately. Then `start_valid` held high while busy on a new op → only one accept and one `done` pulse.
